imem_responder: RTL
===================

Name: imem_responder

Overview:
- Instruction-memory responder: the memory side of the fetch interface. Services PC fetch requests with 32-bit instruction words after a fixed latency.
- Word-addressed SRAM-style array with a loader write port for program preload.
- Flush input kills in-flight responses on branch redirect.
- Sits between the fetch stage and instruction storage.

Parameters:
- XLEN, 32, address width
- DEPTH, 1024, number of 32-bit words (power of 2)
- BASE_ADDR, 0, byte address of word 0
- READ_LAT, 1, request-to-response latency in cycles (legal 1..4; elaboration error otherwise)

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous reset, active-high
- i_req_valid  in  1  fetch request
- i_req_addr  in  XLEN  fetch byte address (PC)
- o_req_ready  out  1  request accepted when valid&&ready
- i_flush  in  1  discard all in-flight responses
- o_rsp_valid  out  1  response valid (single cycle, no backpressure)
- o_rsp_rdata  out  32  instruction word
- o_rsp_err  out  1  misaligned or out-of-range fetch
- i_load_mode  in  1  request loader mode
- i_ld_valid  in  1  loader write strobe
- i_ld_addr  in  XLEN  loader byte address
- i_ld_data  in  32  loader write data
- o_load_active  out  1  FSM is in S_LOAD

Behaviour:
- Reset (i_rst=1 at posedge):
  - FSM to S_RUN; pipeline valids cleared.
  - o_rsp_valid=0, o_rsp_rdata=0, o_rsp_err=0, o_load_active=0.
  - o_req_ready=0 while i_rst is high.
  - Memory array is NOT reset; contents survive reset.
  - Reset mid-load or mid-fetch drops all in-flight responses; loader writes already done are retained.
- FSM states: S_RUN, S_DRAIN, S_LOAD.
  - S_RUN: o_req_ready=1. i_load_mode=1 -> S_DRAIN, and o_req_ready=0 from that cycle on.
  - S_DRAIN: o_req_ready=0. Stays until no pipeline stage is valid, then -> S_LOAD. Flush shortens the drain.
  - S_LOAD: o_req_ready=0, o_load_active=1. Each i_ld_valid writes i_ld_data to word (i_ld_addr-BASE_ADDR)>>2. i_load_mode=0 -> S_RUN next cycle.
  - Loader writes outside S_LOAD are ignored.
- Fetch decode:
  - idx = (addr-BASE_ADDR)>>2, computed at XLEN width with wrap.
  - Misaligned: addr[1:0]!=0.
  - Out-of-range: idx>=DEPTH, or addr<BASE_ADDR.
  - Either condition: response carries err=1 and rdata=NOP (32'h0000_0013). The array is not read.
- Latency: a request accepted at cycle N gives o_rsp_valid=1 at cycle N+READ_LAT. Back-to-back requests give back-to-back responses, in order. Throughput is 1 per cycle.
- Flush:
  - i_flush=1 clears every pipeline valid. A response due in the flush cycle is suppressed.
  - A request accepted in the same cycle as i_flush is kept: it is the redirect target.
- Loader write and fetch never coincide, because reads are blocked outside S_RUN.
- An out-of-range loader address is dropped silently.

Optional Feature:
- Macro: IMEM_PARITY_EN
- Defined:
  - Each word stores an even-parity bit, computed on loader write.
  - Extra port i_ld_par_inject (in, 1) inverts the stored parity bit for that write.
  - On read, a parity mismatch sets o_rsp_err=1 and rdata=NOP.
  - Extra port o_par_err_sticky (out, 1) is set on any mismatch and cleared only by reset.
- Undefined: no parity storage and no extra ports; err comes only from address checks.

Decomposition:
- imem_pkg holds:
  - NOP_INSTR constant (32'h0000_0013)
  - state enum {S_RUN, S_DRAIN, S_LOAD}
  - rsp_t struct {valid, rdata, err}
  - MAX_READ_LAT=4
- Sub-module imem_rsp_pipe: a READ_LAT-deep shift pipeline of rsp_t with a flush input and an any_valid output. The array read sits in stage 0.

Test Plan:
- Preload words 0..3 = 0x11,0x22,0x33,0x44 via S_LOAD. Fetch 0x0,0x4,0x8,0xC back-to-back, READ_LAT=2 -> rsp_valid at cycles N+2..N+5 with data 0x11,0x22,0x33,0x44, err=0.
- Fetch 0x6 -> err=1, rdata=0x00000013. Fetch DEPTH*4 (0x1000) -> err=1, rdata=0x00000013.
- Issue 0x0,0x4, then i_flush together with request 0x8 -> only 0x8's response appears, 2 cycles later.
- Assert i_load_mode with 2 requests in flight -> both responses delivered; o_load_active rises only after the drain; o_req_ready=0 throughout.
- Assert i_rst mid-pipeline -> no response emerges; after reset, fetch 0x4 still returns 0x22.
- With IMEM_PARITY_EN: load word 5 with inject=1, fetch 0x14 -> err=1, rdata=NOP, o_par_err_sticky=1 until reset.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_pkg;

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
    localparam int unsigned MAX_READ_LAT = 4;

    typedef enum logic [1:0] {
        S_RUN,
        S_DRAIN,
        S_LOAD
    } state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

endpackage

// File: rtl/imem_responder_if.sv
// Fetch request/response bus between the fetch stage (master) and the
// instruction memory responder (slave).
interface imem_responder_if #(
    parameter int unsigned XLEN = 32
);
    logic            req_valid;
    logic [XLEN-1:0] req_addr;
    logic            req_ready;
    logic            rsp_valid;
    logic [31:0]     rsp_rdata;
    logic            rsp_err;

    modport master (
        output req_valid, req_addr,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_addr,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/imem_rsp_pipe.sv
// READ_LAT-deep response shift pipeline. Stage 0 captures the array read;
// flush clears every stage except the entry being loaded this cycle.
module imem_rsp_pipe
    import imem_pkg::*;
#(
    parameter int unsigned READ_LAT = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_flush,
    input  rsp_t i_in,
    output rsp_t o_out,
    output logic o_any_valid
);

    rsp_t r_stage [READ_LAT];

    // Shift responses forward one stage per cycle; flush kills older entries.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < READ_LAT; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_in;
            for (int unsigned i = 1; i < READ_LAT; i++) begin
                r_stage[i] <= r_stage[i-1];
                if (i_flush) begin
                    r_stage[i].valid <= 1'b0;
                end
            end
        end
    end

    // Report whether any response is still in flight.
    always_comb begin
        o_any_valid = 1'b0;
        for (int unsigned i = 0; i < READ_LAT; i++) begin
            o_any_valid = o_any_valid | r_stage[i].valid;
        end
    end

    assign o_out = r_stage[READ_LAT-1];

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: word-addressed array serving fetch requests
// after READ_LAT cycles, with a loader port for program preload.
// Optional macro IMEM_PARITY_EN adds per-word even parity, an inject input
// on the loader and a sticky parity-error output.
module imem_responder
    import imem_pkg::*;
#(
    parameter int unsigned     XLEN      = 32,
    parameter int unsigned     DEPTH     = 1024,
    parameter logic [XLEN-1:0] BASE_ADDR = '0,
    parameter int unsigned     READ_LAT  = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    imem_responder_if.slave  fetch,
    input  logic             i_flush,
    input  logic             i_load_mode,
    input  logic             i_ld_valid,
    input  logic [XLEN-1:0]  i_ld_addr,
    input  logic [31:0]      i_ld_data,
`ifdef IMEM_PARITY_EN
    input  logic             i_ld_par_inject,
    output logic             o_par_err_sticky,
`endif
    output logic             o_load_active
);

    if (READ_LAT == 0 || READ_LAT > MAX_READ_LAT) begin : g_bad_read_lat
        $error("imem_responder: READ_LAT must be in 1..%0d", MAX_READ_LAT);
    end

    localparam int unsigned     AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [XLEN-1:0] DEPTH_X = XLEN'(DEPTH);

    // Byte address is inside the array window (offset computed with wrap).
    function automatic logic addr_in_range(input logic [XLEN-1:0] a);
        return (a >= BASE_ADDR) && (((a - BASE_ADDR) >> 2) < DEPTH_X);
    endfunction

    function automatic logic [AW-1:0] addr_index(input logic [XLEN-1:0] a);
        return AW'((a - BASE_ADDR) >> 2);
    endfunction

    state_t        r_state;
    state_t        w_state_nxt;
    logic [31:0]   r_mem [DEPTH];
    rsp_t          w_stage_in;
    rsp_t          w_stage_out;
    logic          w_any_valid;
    logic          w_req_ready;
    logic          w_accept;
    logic          w_addr_err;
    logic          w_par_err;
    logic [AW-1:0] w_rd_idx;
    logic [AW-1:0] w_ld_idx;
    logic          w_ld_we;

    assign w_req_ready = (r_state == S_RUN) && !i_load_mode && !i_rst;
    assign w_accept    = fetch.req_valid && w_req_ready;
    assign w_addr_err  = (fetch.req_addr[1:0] != 2'b00) || !addr_in_range(fetch.req_addr);
    assign w_rd_idx    = addr_index(fetch.req_addr);
    assign w_ld_idx    = addr_index(i_ld_addr);
    assign w_ld_we     = (r_state == S_LOAD) && i_ld_valid && !i_rst && addr_in_range(i_ld_addr);

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: drain in-flight fetches before handing the array to the loader.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_RUN:   if (i_load_mode) w_state_nxt = S_DRAIN;
            S_DRAIN: if (!w_any_valid || i_flush) w_state_nxt = S_LOAD;
            S_LOAD:  if (!i_load_mode) w_state_nxt = S_RUN;
            default: w_state_nxt = S_RUN;
        endcase
    end

    // Loader write port; the array itself is never reset.
    always_ff @(posedge i_clk) begin
        if (w_ld_we) begin
            r_mem[w_ld_idx] <= i_ld_data;
        end
    end

`ifdef IMEM_PARITY_EN
    logic r_par [DEPTH];
    logic r_par_err_sticky;

    // Parity bit stored alongside each loaded word, optionally corrupted.
    always_ff @(posedge i_clk) begin
        if (w_ld_we) begin
            r_par[w_ld_idx] <= (^i_ld_data) ^ i_ld_par_inject;
        end
    end

    assign w_par_err = (^r_mem[w_rd_idx]) != r_par[w_rd_idx];

    // Sticky record of any parity mismatch seen on an accepted fetch.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_par_err_sticky <= 1'b0;
        end else if (w_accept && !w_addr_err && w_par_err) begin
            r_par_err_sticky <= 1'b1;
        end
    end

    assign o_par_err_sticky = r_par_err_sticky;
`else
    assign w_par_err = 1'b0;
`endif

    // Stage-0 response: bad address or parity yields NOP with err set.
    always_comb begin
        w_stage_in = '0;
        if (w_accept) begin
            w_stage_in.valid = 1'b1;
            if (w_addr_err || w_par_err) begin
                w_stage_in.err   = 1'b1;
                w_stage_in.rdata = NOP_INSTR;
            end else begin
                w_stage_in.rdata = r_mem[w_rd_idx];
            end
        end
    end

    imem_rsp_pipe #(
        .READ_LAT (READ_LAT)
    ) u_pipe (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_flush     (i_flush),
        .i_in        (w_stage_in),
        .o_out       (w_stage_out),
        .o_any_valid (w_any_valid)
    );

    // A response leaving the pipe in a flush cycle is suppressed.
    assign fetch.req_ready = w_req_ready;
    assign fetch.rsp_valid = w_stage_out.valid && !i_flush;
    assign fetch.rsp_rdata = w_stage_out.rdata;
    assign fetch.rsp_err   = w_stage_out.err && !i_flush;
    assign o_load_active   = (r_state == S_LOAD);

endmodule
